spi_fl_seq: RTL and testbench
=============================

Name: spi_fl_seq

Overview:
Operation sequencer in front of spi_master_fl. It turns single high-level flash requests into the SPI command sequence each one needs: read, read-ID, page-program or sector-erase. Program and erase requests get an automatic Write Enable before the operation and status polling (RDSR) afterwards until the flash is idle. It sits between the system-side flash controller and spi_master_fl's command/valid/tready interface.

Parameters:
POLL_MAX, 16'hFFFF, maximum RDSR polls before the operation is abandoned with an error.
POLL_GAP, 16, idle clk cycles inserted between consecutive RDSR polls (minimum 1).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
req_op  in  2  0=READ, 1=PROGRAM, 2=ERASE, 3=READ_ID
req_addr  in  24  flash byte address
req_wdata  in  32  program data
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response accept
rsp_rdata  out  32  read data (READ / READ_ID), 0 otherwise
rsp_err  out  1  poll timeout flag
m_command  out  8  to master command
m_commtype  out  3  to master commtype
m_address  out  32  to master address, {8'h00, req_addr}
m_data_in  out  32  to master data_in
m_nmiso_bits  out  7  to master nmiso_bits
m_validflag  out  1  one-cycle start strobe to master
m_data_out  in  32  from master data_out
m_validflag_out  in  1  master transaction-done pulse
m_tready  in  1  master idle/ready

Behaviour:
- Reset (rst=0, async): state=IDLE; every output 0 except req_ready=1 once out of reset; poll counter and gap counter 0.
- All outputs are registered. The request fields are latched on acceptance.
- Commtype encoding: 000 cmd only; 001 cmd+read; 010 cmd+addr+write32; 011 cmd+addr+read; 100 cmd+addr.
- Master handshake:
  - ISSUE states hold m_command/m_commtype/m_address/m_data_in/m_nmiso_bits stable.
  - They pulse m_validflag for exactly one cycle, in the first cycle where m_tready=1, then move to WAIT.
  - WAIT leaves only on m_validflag_out=1; m_data_out is sampled in that cycle.
- States: IDLE, WREN_ISSUE, WREN_WAIT, OP_ISSUE, OP_WAIT, POLL_ISSUE, POLL_WAIT, GAP, DONE.
- IDLE -> WREN_ISSUE for PROGRAM/ERASE; IDLE -> OP_ISSUE for READ/READ_ID.
- WREN: cmd 0x06, commtype 000. WREN_WAIT -> OP_ISSUE.
- OP per request type:
  - READ: 0x03 / 011 / nmiso 32; rdata = m_data_out; -> DONE.
  - READ_ID: 0x9F / 001 / nmiso 24; rdata = {8'h00, m_data_out[23:0]}; -> DONE.
  - PROGRAM: 0x02 / 010 / data_in = wdata; -> POLL_ISSUE.
  - ERASE: 0x20 / 100; -> POLL_ISSUE.
- POLL: RDSR 0x05 / 001 / nmiso 8. In POLL_WAIT on done:
  - m_data_out[0]=0 -> DONE, err=0.
  - otherwise poll_cnt+1; if poll_cnt+1 == POLL_MAX -> DONE, err=1; else GAP.
- GAP: count POLL_GAP cycles, then POLL_ISSUE. poll_cnt clears on request accept.
- DONE: rsp_valid=1 with rsp_rdata/rsp_err stable. rsp_ready=1 in the same cycle rsp_valid first rises is a legal accept; IDLE follows next cycle.
- req_valid while not in IDLE: ignored, with no side effects.
- m_validflag_out outside a WAIT state: ignored.
- Reset mid-operation: immediate IDLE with no response emitted; spi_master_fl shares the same reset.
- Latency: IDLE to first m_validflag is 1 cycle when m_tready=1.

Decomposition:
- Package spi_fl_pkg holds:
  - op codes (READ/PROGRAM/ERASE/READ_ID);
  - flash opcodes (0x06, 0x03, 0x02, 0x20, 0x05, 0x9F);
  - commtype encodings;
  - state enum.
- One natural sub-module: spi_fl_issue. It is the ISSUE/WAIT handshake unit: it waits for tready, pulses validflag, waits for validflag_out, and returns done plus captured data. The FSM reuses it for every command phase.

Test Plan:
- Bench setup: a behavioural flash model sits on MISO behind spi_master_fl.
- READ at 0x555555, model returns 0xA0A0A0A3: one master transaction (0x03, commtype 011, nmiso 32) -> rsp_rdata=0xA0A0A0A3, rsp_err=0.
- READ_ID, model ID 0xEF4018: single 0x9F transaction -> rsp_rdata=0x00EF4018.
- PROGRAM 0x000100 data 0x5A5A5A5A, WIP busy for 3 polls: sequence 0x06, 0x02, then 0x05 four times -> rsp_err=0, with ≥POLL_GAP cycles between polls.
- ERASE with WIP stuck at 1 and POLL_MAX=4: exactly four RDSR polls -> rsp_err=1, then IDLE.
- Backpressure: m_tready held low 10 cycles -> no m_validflag until tready=1. rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable. A second req_valid during busy -> ignored.
- Reset asserted mid PROGRAM (in POLL_WAIT) -> all outputs 0 and req_ready=1 after release. A following READ completes normally.

Source files
------------

// File: rtl/spi_fl_pkg.sv
// Shared definitions for the SPI flash operation sequencer: request ops, flash
// opcodes, master commtype encodings, FSM states and per-phase command lookup.
package spi_fl_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_READ_ID = 2'd3
  } op_t;

  localparam logic [7:0] FL_WREN = 8'h06;
  localparam logic [7:0] FL_READ = 8'h03;
  localparam logic [7:0] FL_PP   = 8'h02;
  localparam logic [7:0] FL_SE   = 8'h20;
  localparam logic [7:0] FL_RDSR = 8'h05;
  localparam logic [7:0] FL_RDID = 8'h9F;

  localparam logic [2:0] CT_CMD       = 3'b000;
  localparam logic [2:0] CT_CMD_RD    = 3'b001;
  localparam logic [2:0] CT_ADDR_WR32 = 3'b010;
  localparam logic [2:0] CT_ADDR_RD   = 3'b011;
  localparam logic [2:0] CT_ADDR      = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN_ISSUE,
    S_WREN_WAIT,
    S_OP_ISSUE,
    S_OP_WAIT,
    S_POLL_ISSUE,
    S_POLL_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] command;
    logic [2:0] commtype;
    logic [6:0] nmiso_bits;
  } cmd_t;

  function automatic logic is_issue(state_t st);
    return st inside {S_WREN_ISSUE, S_OP_ISSUE, S_POLL_ISSUE};
  endfunction

  function automatic logic is_wait(state_t st);
    return st inside {S_WREN_WAIT, S_OP_WAIT, S_POLL_WAIT};
  endfunction

  // Command fields presented to the master while in a given ISSUE state.
  function automatic cmd_t phase_cmd(state_t st, op_t op);
    cmd_t c;
    c = '{FL_RDSR, CT_CMD_RD, 7'd8};
    if (st == S_WREN_ISSUE) begin
      c = '{FL_WREN, CT_CMD, 7'd0};
    end else if (st == S_OP_ISSUE) begin
      case (op)
        OP_READ:    c = '{FL_READ, CT_ADDR_RD,   7'd32};
        OP_READ_ID: c = '{FL_RDID, CT_CMD_RD,    7'd24};
        OP_PROGRAM: c = '{FL_PP,   CT_ADDR_WR32, 7'd0};
        default:    c = '{FL_SE,   CT_ADDR,      7'd0};
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_fl_issue.sv
// Master handshake unit: waits for tready, emits a one-cycle validflag, then
// reports done together with the master's returned data word.
module spi_fl_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_issue,
  input  logic        i_wait,
  input  logic        i_tready,
  input  logic        i_validflag_out,
  input  logic [31:0] i_data_out,
  output logic        o_validflag,
  output logic        o_launch,
  output logic        o_done,
  output logic [31:0] o_data
);

  logic r_validflag;

  assign o_launch    = i_issue & i_tready;
  assign o_done      = i_wait & i_validflag_out;
  assign o_data      = i_data_out;
  assign o_validflag = r_validflag;

  // The owning FSM leaves ISSUE on the same edge, so this is a single pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_validflag <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_validflag <= o_launch;
    end
  end

endmodule

// File: rtl/spi_fl_seq.sv
// Flash operation sequencer: expands READ / READ_ID / PROGRAM / ERASE requests
// into WREN, operation and RDSR-polling transactions on spi_master_fl.
module spi_fl_seq
  import spi_fl_pkg::*;
#(
  parameter logic [15:0] POLL_MAX = 16'hFFFF,
  parameter logic [15:0] POLL_GAP = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  m_command,
  output logic [2:0]  m_commtype,
  output logic [31:0] m_address,
  output logic [31:0] m_data_in,
  output logic [6:0]  m_nmiso_bits,
  output logic        m_validflag,
  input  logic [31:0] m_data_out,
  input  logic        m_validflag_out,
  input  logic        m_tready
);

  state_t      r_state;
  op_t         r_op;
  logic [23:0] r_addr;
  logic [31:0] r_wdata;
  logic [15:0] r_poll_cnt;
  logic [15:0] r_gap_cnt;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [7:0]  r_m_command;
  logic [2:0]  r_m_commtype;
  logic [31:0] r_m_address;
  logic [31:0] r_m_data_in;
  logic [6:0]  r_m_nmiso;

  state_t      w_next_state;
  logic        w_accept;
  logic        w_launch;
  logic        w_done;
  logic [31:0] w_data;
  logic [15:0] w_poll_inc;
  op_t         w_op_src;
  logic [23:0] w_addr_src;
  logic [31:0] w_wdata_src;
  cmd_t        w_cmd;

  assign w_accept    = req_valid & r_req_ready & (r_state == S_IDLE);
  assign w_poll_inc  = r_poll_cnt + 16'd1;
  // On the accept edge the request fields are not latched yet; use the inputs.
  assign w_op_src    = w_accept ? op_t'(req_op) : r_op;
  assign w_addr_src  = w_accept ? req_addr : r_addr;
  assign w_wdata_src = w_accept ? req_wdata : r_wdata;
  assign w_cmd       = phase_cmd(w_next_state, w_op_src);

  spi_fl_issue u_issue (
    .clk             (clk),
    .rst             (rst),
    .i_issue         (is_issue(r_state)),
    .i_wait          (is_wait(r_state)),
    .i_tready        (m_tready),
    .i_validflag_out (m_validflag_out),
    .i_data_out      (m_data_out),
    .o_validflag     (m_validflag),
    .o_launch        (w_launch),
    .o_done          (w_done),
    .o_data          (w_data)
  );

  always_comb begin
    // NOTE: default first so no path through the case leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = (op_t'(req_op) inside {OP_PROGRAM, OP_ERASE}) ? S_WREN_ISSUE : S_OP_ISSUE;
        end
      end
      S_WREN_ISSUE: if (w_launch) w_next_state = S_WREN_WAIT;
      S_WREN_WAIT:  if (w_done)   w_next_state = S_OP_ISSUE;
      S_OP_ISSUE:   if (w_launch) w_next_state = S_OP_WAIT;
      S_OP_WAIT: begin
        if (w_done) begin
          w_next_state = (r_op inside {OP_READ, OP_READ_ID}) ? S_DONE : S_POLL_ISSUE;
        end
      end
      S_POLL_ISSUE: if (w_launch) w_next_state = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (w_done) begin
          if (!w_data[0] || (w_poll_inc == POLL_MAX)) w_next_state = S_DONE;
          else                                         w_next_state = S_GAP;
        end
      end
      S_GAP:  if (r_gap_cnt == POLL_GAP - 16'd1) w_next_state = S_POLL_ISSUE;
      S_DONE: if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_READ;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_poll_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_m_command  <= '0;
      r_m_commtype <= '0;
      r_m_address  <= '0;
      r_m_data_in  <= '0;
      r_m_nmiso    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == S_IDLE);
      r_rsp_valid <= (w_next_state == S_DONE);
      r_gap_cnt   <= (r_state == S_GAP) ? r_gap_cnt + 16'd1 : 16'd0;

      if (w_accept) begin
        r_op        <= op_t'(req_op);
        r_addr      <= req_addr;
        r_wdata     <= req_wdata;
        r_poll_cnt  <= '0;
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b0;
      end

      if (is_issue(w_next_state)) begin
        r_m_command  <= w_cmd.command;
        r_m_commtype <= w_cmd.commtype;
        r_m_nmiso    <= w_cmd.nmiso_bits;
        r_m_address  <= {8'h00, w_addr_src};
        r_m_data_in  <= (w_next_state == S_OP_ISSUE && w_op_src == OP_PROGRAM) ? w_wdata_src : '0;
      end

      if (r_state == S_OP_WAIT && w_done) begin
        if (r_op == OP_READ)         r_rsp_rdata <= w_data;
        else if (r_op == OP_READ_ID) r_rsp_rdata <= {8'h00, w_data[23:0]};
      end

      if (r_state == S_POLL_WAIT && w_done && w_data[0]) begin
        r_poll_cnt <= w_poll_inc;
        if (w_poll_inc == POLL_MAX) r_rsp_err <= 1'b1;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign m_command    = r_m_command;
  assign m_commtype   = r_m_commtype;
  assign m_address    = r_m_address;
  assign m_data_in    = r_m_data_in;
  assign m_nmiso_bits = r_m_nmiso;

endmodule

// File: tb/tb_spi_fl_seq.sv
// Bench for spi_fl_seq: a behavioural spi_master_fl + flash model answers
// transactions; expected transactions and responses are scoreboarded in queues.
module tb_spi_fl_seq;
  import spi_fl_pkg::*;

  localparam logic [15:0] P_POLL_MAX = 16'd4;
  localparam logic [15:0] P_POLL_GAP = 16'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [23:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  m_command;
  logic [2:0]  m_commtype;
  logic [31:0] m_address;
  logic [31:0] m_data_in;
  logic [6:0]  m_nmiso_bits;
  logic        m_validflag;
  logic [31:0] m_data_out;
  logic        m_validflag_out;
  logic        m_tready;

  always #5 clk = ~clk;

  spi_fl_seq #(.POLL_MAX(P_POLL_MAX), .POLL_GAP(P_POLL_GAP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_command(m_command), .m_commtype(m_commtype), .m_address(m_address),
    .m_data_in(m_data_in), .m_nmiso_bits(m_nmiso_bits), .m_validflag(m_validflag),
    .m_data_out(m_data_out), .m_validflag_out(m_validflag_out), .m_tready(m_tready)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [2:0]  ct;
    logic [31:0] addr;
    logic [31:0] din;
    logic [6:0]  nmiso;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  txn_t exp_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] fl_read_word = '0;
  logic [31:0] fl_id_word = '0;
  int          fl_wip_left = 0;
  bit          fl_wip_stuck = 1'b0;
  bit          mst_busy = 1'b0;
  int          mst_lat = 0;
  logic [7:0]  mst_cmd = '0;
  bit          tready_hold = 1'b0;
  bit          inject_done = 1'b0;
  int          vf_first = -1;
  int          req_cyc = 0;
  int          last_rdsr_done = -1;
  int          rdsr_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic txn_t mk(logic [7:0] cmd, logic [2:0] ct, logic [23:0] addr,
                              logic [31:0] din, logic [6:0] nmiso);
    txn_t t;
    t.cmd = cmd; t.ct = ct; t.addr = {8'h00, addr}; t.din = din; t.nmiso = nmiso;
    return t;
  endfunction

  // Behavioural master + flash: checks each launched transaction against the
  // scoreboard and answers it a few cycles later.
  initial begin
    txn_t e;
    bit   ok;
    m_tready = 1'b0;
    m_validflag_out = 1'b0;
    m_data_out = '0;
    forever begin
      @(negedge clk);
      m_validflag_out = 1'b0;
      if (!rst) begin
        mst_busy = 1'b0;
        m_tready = 1'b0;
      end else begin
        if (m_validflag) begin
          total++;
          if (mst_busy || !m_tready) begin
            bad++;
            $display("FAIL vf_handshake: validflag=1 with busy=%0d tready=%0d", mst_busy, m_tready);
          end
          if (vf_first < 0) vf_first = cyc;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_txn: got cmd=%h ct=%b, none expected", m_command, m_commtype);
          end else begin
            e = exp_q.pop_front();
            ok = (m_command === e.cmd) && (m_commtype === e.ct) && (m_address === e.addr);
            if (e.ct == CT_ADDR_WR32) ok = ok && (m_data_in === e.din);
            if (e.ct == CT_CMD_RD || e.ct == CT_ADDR_RD) ok = ok && (m_nmiso_bits === e.nmiso);
            if (!ok) begin
              bad++;
              $display("FAIL txn: got cmd=%h ct=%b addr=%h din=%h nmiso=%0d, need cmd=%h ct=%b addr=%h din=%h nmiso=%0d",
                       m_command, m_commtype, m_address, m_data_in, m_nmiso_bits,
                       e.cmd, e.ct, e.addr, e.din, e.nmiso);
            end
          end
          if (m_command == FL_RDSR) begin
            rdsr_seen++;
            if (last_rdsr_done >= 0) begin
              total++;
              if (cyc - last_rdsr_done < int'(P_POLL_GAP)) begin
                bad++;
                $display("FAIL poll_gap: got %0d cycles, need >= %0d", cyc - last_rdsr_done, P_POLL_GAP);
              end
            end
          end
          mst_cmd = m_command;
          mst_busy = 1'b1;
          mst_lat = 3;
        end else if (mst_busy) begin
          if (mst_lat == 0) begin
            m_validflag_out = 1'b1;
            mst_busy = 1'b0;
            case (mst_cmd)
              FL_READ: m_data_out = fl_read_word;
              FL_RDID: m_data_out = fl_id_word;
              FL_RDSR: begin
                last_rdsr_done = cyc;
                if (fl_wip_stuck) m_data_out = 32'h0000_0003;
                else if (fl_wip_left > 0) begin
                  m_data_out = 32'h0000_0003;
                  fl_wip_left--;
                end else m_data_out = 32'h0000_0000;
              end
              default: m_data_out = 32'h0BAD_F00D;
            endcase
          end else begin
            mst_lat--;
          end
        end else if (inject_done) begin
          m_validflag_out = 1'b1;
          m_data_out = 32'hFFFF_FFFF;
          inject_done = 1'b0;
        end
        m_tready = !mst_busy && !tready_hold;
      end
    end
  end

  task automatic send_req(input op_t op, input logic [23:0] addr, input logic [31:0] wdata);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL req_ready_timeout: got req_ready=%b, need 1", req_ready);
    end
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wdata;
    vf_first = -1;
    req_cyc = cyc;
    last_rdsr_done = -1;
    rdsr_seen = 0;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL accept_busy: got req_ready=%b, need 0", req_ready);
    end
  endtask

  task automatic wait_rsp(input string name, input int hold);
    rsp_t e;
    int   n = 0;
    while (rsp_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_rsp_timeout: got rsp_valid=%b queued=%0d, need 1", name, rsp_valid, rsp_q.size());
    end else begin
      e = rsp_q.pop_front();
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        bad++;
        $display("FAIL %s_rsp: got rdata=%h err=%b, need rdata=%h err=%b", name, rsp_rdata, rsp_err, e.rdata, e.err);
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          bad++;
          $display("FAIL %s_rsp_hold: got valid=%b rdata=%h err=%b, need 1/%h/%b", name, rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s_release: got rsp_valid=%b req_ready=%b, need 0/1", name, rsp_valid, req_ready);
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_txn_count: got %0d pending txns, need 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, m_command, m_commtype, m_address,
         m_data_in, m_nmiso_bits, m_validflag} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b cmd=%h addr=%h, need all 0", req_ready, rsp_valid, m_command, m_address);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || m_validflag !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got req_ready=%b rsp_valid=%b vf=%b, need 1/0/0", req_ready, rsp_valid, m_validflag);
    end
  endtask

  task automatic test_read();
    fl_read_word = 32'hA0A0_A0A3;
    exp_q.push_back(mk(FL_READ, CT_ADDR_RD, 24'h555555, 32'h0, 7'd32));
    rsp_q.push_back('{32'hA0A0_A0A3, 1'b0});
    send_req(OP_READ, 24'h555555, 32'h0);
    wait_rsp("read", 0);
    total++;
    if (vf_first < 0 || vf_first - req_cyc > 2) begin
      bad++;
      $display("FAIL read_latency: got %0d cycles, need <= 2", vf_first - req_cyc);
    end
  endtask

  task automatic test_read_id();
    fl_id_word = 32'hAAEF_4018;
    exp_q.push_back(mk(FL_RDID, CT_CMD_RD, 24'h000000, 32'h0, 7'd24));
    rsp_q.push_back('{32'h00EF_4018, 1'b0});
    send_req(OP_READ_ID, 24'h000000, 32'h0);
    wait_rsp("read_id", 0);
  endtask

  task automatic test_program();
    fl_wip_left = 3;
    exp_q.push_back(mk(FL_WREN, CT_CMD, 24'h000100, 32'h0, 7'd0));
    exp_q.push_back(mk(FL_PP, CT_ADDR_WR32, 24'h000100, 32'h5A5A_5A5A, 7'd0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(FL_RDSR, CT_CMD_RD, 24'h000100, 32'h0, 7'd8));
    rsp_q.push_back('{32'h0, 1'b0});
    send_req(OP_PROGRAM, 24'h000100, 32'h5A5A_5A5A);
    wait_rsp("program", 0);
  endtask

  task automatic test_erase_timeout();
    fl_wip_stuck = 1'b1;
    exp_q.push_back(mk(FL_WREN, CT_CMD, 24'h012000, 32'h0, 7'd0));
    exp_q.push_back(mk(FL_SE, CT_ADDR, 24'h012000, 32'h0, 7'd0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(FL_RDSR, CT_CMD_RD, 24'h012000, 32'h0, 7'd8));
    rsp_q.push_back('{32'h0, 1'b1});
    send_req(OP_ERASE, 24'h012000, 32'h0);
    wait_rsp("erase_timeout", 0);
    fl_wip_stuck = 1'b0;
    total++;
    if (rdsr_seen != 4) begin
      bad++;
      $display("FAIL erase_poll_count: got %0d polls, need 4", rdsr_seen);
    end
  endtask

  task automatic test_backpressure();
    fl_read_word = 32'h1357_9BDF;
    tready_hold = 1'b1;
    exp_q.push_back(mk(FL_READ, CT_ADDR_RD, 24'h00C0DE, 32'h0, 7'd32));
    rsp_q.push_back('{32'h1357_9BDF, 1'b0});
    send_req(OP_READ, 24'h00C0DE, 32'h0);
    req_valid = 1'b1;
    req_op = OP_PROGRAM;
    req_addr = 24'hFFFFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (m_validflag !== 1'b0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL tready_hold: got vf=%b req_ready=%b, need 0/0", m_validflag, req_ready);
      end
    end
    req_valid = 1'b0;
    tready_hold = 1'b0;
    wait_rsp("backpressure", 5);
  endtask

  task automatic test_back_to_back();
    fl_read_word = 32'hCAFE_0001;
    fl_id_word = 32'h00C2_2017;
    inject_done = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || m_validflag !== 1'b0) begin
      bad++;
      $display("FAIL stray_done: got rsp_valid=%b req_ready=%b vf=%b, need 0/1/0", rsp_valid, req_ready, m_validflag);
    end
    rsp_ready = 1'b1;
    exp_q.push_back(mk(FL_READ, CT_ADDR_RD, 24'h000040, 32'h0, 7'd32));
    rsp_q.push_back('{32'hCAFE_0001, 1'b0});
    send_req(OP_READ, 24'h000040, 32'h0);
    wait_rsp("b2b_read", 0);
    rsp_ready = 1'b1;
    exp_q.push_back(mk(FL_RDID, CT_CMD_RD, 24'h000041, 32'h0, 7'd24));
    rsp_q.push_back('{32'h00C2_2017, 1'b0});
    send_req(OP_READ_ID, 24'h000041, 32'h0);
    wait_rsp("b2b_read_id", 0);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fl_wip_stuck = 1'b1;
    exp_q.push_back(mk(FL_WREN, CT_CMD, 24'h000200, 32'h0, 7'd0));
    exp_q.push_back(mk(FL_PP, CT_ADDR_WR32, 24'h000200, 32'h1111_2222, 7'd0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(FL_RDSR, CT_CMD_RD, 24'h000200, 32'h0, 7'd8));
    send_req(OP_PROGRAM, 24'h000200, 32'h1111_2222);
    while (!(rdsr_seen >= 2 && mst_busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!(rdsr_seen >= 2 && mst_busy)) begin
      bad++;
      $display("FAIL mid_poll_timeout: got %0d polls, need 2 in flight", rdsr_seen);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rsp_q.delete();
    fl_wip_stuck = 1'b0;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, m_command, m_commtype, m_address,
         m_data_in, m_nmiso_bits, m_validflag} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got rdy=%b vld=%b cmd=%h addr=%h, need all 0", req_ready, rsp_valid, m_command, m_address);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_release: got req_ready=%b rsp_valid=%b, need 1/0", req_ready, rsp_valid);
    end
    fl_read_word = 32'h1234_5678;
    exp_q.push_back(mk(FL_READ, CT_ADDR_RD, 24'h000ABC, 32'h0, 7'd32));
    rsp_q.push_back('{32'h1234_5678, 1'b0});
    send_req(OP_READ, 24'h000ABC, 32'h0);
    wait_rsp("after_reset_read", 0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_read_id();
    test_program();
    test_erase_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
